// File: rtl/pulpemu_spi_pkg.sv
// Shared types and constants for the PULP emulator SPI source arbiter.
package pulpemu_spi_pkg;

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_BLANK  = 2'd2,
        ST_ARM    = 2'd3
    } state_e;

    localparam logic [1:0] SPI_STD     = 2'b00;
    localparam logic [1:0] SPI_QUAD_TX = 2'b01;
    localparam logic [1:0] SPI_QUAD_RX = 2'b10;

    localparam logic IDLE_CLK = 1'b0;
    localparam logic IDLE_CSN = 1'b1;
    localparam logic IDLE_SDI = 1'b0;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pulpemu_spi_csn_sync.sv
// Chip-select synchroniser for one SPI source plus all-deasserted detect.
module pulpemu_spi_csn_sync #(
    parameter int NUM_CS      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CS-1:0] csn_i,
    output logic              idle_o
);

    logic [SYNC_STAGES-1:0][NUM_CS-1:0] sync_pipe;

    // Reset to "selected" so a source is never treated as idle before its real CSN has propagated.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_pipe <= '0;
        else     sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], csn_i};
    end

    assign idle_o = &sync_pipe[SYNC_STAGES-1];

endmodule

// File: rtl/pulpemu_spi_src_arbiter.sv
// Glitch-free N-source SPI master selector in front of the PULP SPI slave.
module pulpemu_spi_src_arbiter
    import pulpemu_spi_pkg::*;
#(
    parameter int NUM_SRC       = 2,
    parameter int NUM_CS        = 4,
    parameter int NUM_DQ        = 4,
    parameter int GUARD_CYCLES  = 8,
    parameter int DRAIN_TIMEOUT = 0,
    parameter int RST_SRC       = 0,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        sel_valid_i,
    output logic                        sel_ready_o,
    input  logic [$clog2(NUM_SRC)-1:0]  sel_src_i,
    output logic [$clog2(NUM_SRC)-1:0]  cur_src_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        err_bad_src_o,
    output logic                        err_abort_o,
    input  logic                        err_clr_i,
    input  logic [NUM_SRC-1:0]          src_clk_i,
    input  logic [NUM_SRC*NUM_CS-1:0]   src_csn_i,
    input  logic [NUM_SRC*NUM_DQ-1:0]   src_mosi_i,
    output logic [NUM_SRC*NUM_DQ-1:0]   src_miso_o,
    output logic [NUM_SRC*2-1:0]        src_mode_o,
    output logic                        pulp_spi_clk_o,
    output logic [NUM_CS-1:0]           pulp_spi_csn_o,
    output logic [NUM_DQ-1:0]           pulp_spi_sdi_o,
    input  logic [NUM_DQ-1:0]           pulp_spi_sdo_i,
    input  logic [1:0]                  pulp_spi_mode_i
);

    localparam int SRC_W   = $clog2(NUM_SRC);
    localparam int CNT_MAX = max_int(GUARD_CYCLES, DRAIN_TIMEOUT);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] GUARD_C = CNT_W'(GUARD_CYCLES);
    localparam logic [CNT_W-1:0] TMO_C   = CNT_W'(DRAIN_TIMEOUT);
    localparam logic [CNT_W-1:0] SAT_C   = CNT_W'(CNT_MAX);

    state_e             state;
    logic [SRC_W-1:0]   cur_src, tgt_src;
    logic [CNT_W-1:0]   idle_cnt, drain_cnt, blank_cnt;
    logic [CNT_W-1:0]   idle_inc, drain_inc, blank_inc;
    logic               switching, done_q, err_bad_q, err_abort_q;
    logic [NUM_SRC-1:0] idle_vec;
    logic               idle_cur, accept, bad_src, guard_hit, timeout_hit, connected;

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_sync
        pulpemu_spi_csn_sync #(
            .NUM_CS      (NUM_CS),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_csn_sync (
            .clk    (clk),
            .rst    (rst),
            .csn_i  (src_csn_i[s*NUM_CS +: NUM_CS]),
            .idle_o (idle_vec[s])
        );
    end

    assign idle_cur    = idle_vec[cur_src];
    assign idle_inc    = (idle_cnt  == SAT_C) ? idle_cnt  : idle_cnt  + 1'b1;
    assign drain_inc   = (drain_cnt == SAT_C) ? drain_cnt : drain_cnt + 1'b1;
    assign blank_inc   = (blank_cnt == SAT_C) ? blank_cnt : blank_cnt + 1'b1;
    assign accept      = sel_valid_i && sel_ready_o;
    assign bad_src     = int'(sel_src_i) >= NUM_SRC;
    assign guard_hit   = (state == ST_DRAIN) && idle_cur && (idle_inc == GUARD_C);
    assign timeout_hit = (state == ST_DRAIN) && !guard_hit && (DRAIN_TIMEOUT != 0) &&
                         (drain_inc == TMO_C);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_ARM;
            cur_src     <= SRC_W'(RST_SRC);
            tgt_src     <= SRC_W'(RST_SRC);
            idle_cnt    <= '0;
            drain_cnt   <= '0;
            blank_cnt   <= '0;
            switching   <= 1'b0;
            done_q      <= 1'b0;
            err_bad_q   <= 1'b0;
            err_abort_q <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            err_bad_q   <= (accept && bad_src) || (err_bad_q && !err_clr_i);
            err_abort_q <= timeout_hit || (err_abort_q && !err_clr_i);
            case (state)
                ST_ACTIVE: begin
                    if (accept && !bad_src) begin
                        if (sel_src_i == cur_src) begin
                            done_q <= 1'b1;
                        end else begin
                            tgt_src   <= sel_src_i;
                            idle_cnt  <= '0;
                            drain_cnt <= '0;
                            switching <= 1'b1;
                            state     <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    idle_cnt  <= idle_cur ? idle_inc : '0;
                    drain_cnt <= drain_inc;
                    if (guard_hit || timeout_hit) begin
                        blank_cnt <= '0;
                        state     <= ST_BLANK;
                    end
                end
                ST_BLANK: begin
                    blank_cnt <= blank_inc;
                    if (blank_inc == GUARD_C) begin
                        cur_src <= tgt_src;
                        state   <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    // Only a real switch reports completion; the post-reset arm is silent.
                    if (idle_cur) begin
                        done_q    <= switching;
                        switching <= 1'b0;
                        state     <= ST_ACTIVE;
                    end
                end
                default: state <= ST_ARM;
            endcase
        end
    end

    // DRAIN keeps the old source wired through so its in-flight frame completes intact.
    assign connected = (state == ST_ACTIVE) || (state == ST_DRAIN);

    assign pulp_spi_clk_o = connected ? src_clk_i[cur_src] : IDLE_CLK;
    assign pulp_spi_csn_o = connected ? src_csn_i[cur_src*NUM_CS +: NUM_CS] : {NUM_CS{IDLE_CSN}};
    assign pulp_spi_sdi_o = connected ? src_mosi_i[cur_src*NUM_DQ +: NUM_DQ] : {NUM_DQ{IDLE_SDI}};

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_ret
        logic sel_s;
        assign sel_s = connected && (cur_src == SRC_W'(s));
        assign src_miso_o[s*NUM_DQ +: NUM_DQ] = sel_s ? pulp_spi_sdo_i : '0;
        assign src_mode_o[s*2 +: 2]           = sel_s ? pulp_spi_mode_i : SPI_STD;
    end

    assign sel_ready_o   = (state == ST_ACTIVE);
    assign busy_o        = (state != ST_ACTIVE);
    assign done_o        = done_q;
    assign cur_src_o     = cur_src;
    assign err_bad_src_o = err_bad_q;
    assign err_abort_o   = err_abort_q;

endmodule

// File: tb/tb_pulpemu_spi_src_arbiter.sv
// Directed bench for the SPI source arbiter: 3 sources, quad lanes, drain timeout of 50.
module tb_pulpemu_spi_src_arbiter;

    localparam int NS = 3;
    localparam int NC = 4;
    localparam int ND = 4;

    logic            clk, rst;
    logic            sel_valid_i, sel_ready_o, busy_o, done_o;
    logic [1:0]      sel_src_i, cur_src_o;
    logic            err_bad_src_o, err_abort_o, err_clr_i;
    logic [NS-1:0]   src_clk_i;
    logic [NS*NC-1:0] src_csn_i;
    logic [NS*ND-1:0] src_mosi_i, src_miso_o;
    logic [NS*2-1:0] src_mode_o;
    logic            pulp_spi_clk_o;
    logic [NC-1:0]   pulp_spi_csn_o;
    logic [ND-1:0]   pulp_spi_sdi_o, pulp_spi_sdo_i;
    logic [1:0]      pulp_spi_mode_i;

    logic [NC-1:0]   csn  [NS];
    logic [ND-1:0]   mosi [NS];
    int              n_tests = 0;
    int              n_fail  = 0;

    assign src_csn_i  = {csn[2], csn[1], csn[0]};
    assign src_mosi_i = {mosi[2], mosi[1], mosi[0]};

    pulpemu_spi_src_arbiter #(
        .NUM_SRC(NS), .NUM_CS(NC), .NUM_DQ(ND), .GUARD_CYCLES(8),
        .DRAIN_TIMEOUT(50), .RST_SRC(0), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .rst(rst),
        .sel_valid_i(sel_valid_i), .sel_ready_o(sel_ready_o), .sel_src_i(sel_src_i),
        .cur_src_o(cur_src_o), .busy_o(busy_o), .done_o(done_o),
        .err_bad_src_o(err_bad_src_o), .err_abort_o(err_abort_o), .err_clr_i(err_clr_i),
        .src_clk_i(src_clk_i), .src_csn_i(src_csn_i), .src_mosi_i(src_mosi_i),
        .src_miso_o(src_miso_o), .src_mode_o(src_mode_o),
        .pulp_spi_clk_o(pulp_spi_clk_o), .pulp_spi_csn_o(pulp_spi_csn_o),
        .pulp_spi_sdi_o(pulp_spi_sdi_o), .pulp_spi_sdo_i(pulp_spi_sdo_i),
        .pulp_spi_mode_i(pulp_spi_mode_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [1:0] src);
        sel_valid_i = 1'b1;
        sel_src_i   = src;
        step();
        sel_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        int cyc;
        rst = 1'b1; sel_valid_i = 0; sel_src_i = 0; err_clr_i = 0;
        src_clk_i = '1; pulp_spi_sdo_i = 4'hA; pulp_spi_mode_i = 2'b01;
        for (int s = 0; s < NS; s++) begin csn[s] = 4'hF; mosi[s] = 4'h5; end
        step(); step();
        n_tests++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL reset_busy got=%b exp=1", busy_o); end
        n_tests++; if (sel_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", sel_ready_o); end
        n_tests++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done_o); end
        n_tests++; if (cur_src_o !== 2'd0) begin n_fail++; $display("FAIL reset_cur got=%0d exp=0", cur_src_o); end
        n_tests++; if ({err_bad_src_o, err_abort_o} !== 2'b00) begin n_fail++; $display("FAIL reset_err got=%b exp=00", {err_bad_src_o, err_abort_o}); end
        n_tests++; if ({pulp_spi_clk_o, pulp_spi_csn_o, pulp_spi_sdi_o} !== 9'b0_1111_0000) begin
            n_fail++; $display("FAIL reset_idle_pattern got=%b exp=011110000", {pulp_spi_clk_o, pulp_spi_csn_o, pulp_spi_sdi_o}); end
        n_tests++; if ({src_miso_o, src_mode_o} !== '0) begin n_fail++; $display("FAIL reset_ret got=%h exp=0", {src_miso_o, src_mode_o}); end
        src_clk_i = '0; pulp_spi_sdo_i = 4'h0; pulp_spi_mode_i = 2'b00;
        rst = 1'b0;
        cyc = 0;
        while (busy_o === 1'b1 && cyc < 10) begin
            step(); cyc++;
            n_tests++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_arm_done got=%b exp=0 cyc=%0d", done_o, cyc); end
        end
        n_tests++; if (cyc != 3 || busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_arm_len got=%0d exp=3 busy=%b", cyc, busy_o); end
    endtask

    task automatic test_drain_switch();
        csn[0] = 4'hE; src_clk_i[0] = 1'b1; mosi[0] = 4'h5; mosi[1] = 4'hC; csn[1] = 4'hF;
        #1;
        n_tests++; if ({pulp_spi_clk_o, pulp_spi_csn_o, pulp_spi_sdi_o} !== 9'b1_1110_0101) begin
            n_fail++; $display("FAIL pass_src0 got=%b exp=111100101", {pulp_spi_clk_o, pulp_spi_csn_o, pulp_spi_sdi_o}); end
        request(2'd1);
        n_tests++; if ({busy_o, sel_ready_o} !== 2'b10) begin n_fail++; $display("FAIL drain_enter got=%b exp=10", {busy_o, sel_ready_o}); end
        repeat (3) step();
        n_tests++; if (pulp_spi_csn_o !== 4'hE || pulp_spi_sdi_o !== 4'h5) begin
            n_fail++; $display("FAIL drain_hold csn=%h sdi=%h exp=e 5", pulp_spi_csn_o, pulp_spi_sdi_o); end
        csn[0] = 4'hF; src_clk_i[0] = 1'b0;
        repeat (9) step();
        n_tests++; if (busy_o !== 1'b1 || pulp_spi_sdi_o !== 4'h5) begin
            n_fail++; $display("FAIL drain_guard busy=%b sdi=%h exp=1 5", busy_o, pulp_spi_sdi_o); end
        step();
        n_tests++; if (pulp_spi_sdi_o !== 4'h0 || pulp_spi_csn_o !== 4'hF || cur_src_o !== 2'd0) begin
            n_fail++; $display("FAIL blank_enter sdi=%h csn=%h cur=%0d exp=0 f 0", pulp_spi_sdi_o, pulp_spi_csn_o, cur_src_o); end
        repeat (7) step();
        n_tests++; if (cur_src_o !== 2'd0 || pulp_spi_sdi_o !== 4'h0) begin
            n_fail++; $display("FAIL blank_hold cur=%0d sdi=%h exp=0 0", cur_src_o, pulp_spi_sdi_o); end
        step();
        n_tests++; if (cur_src_o !== 2'd1 || busy_o !== 1'b1 || done_o !== 1'b0 || pulp_spi_sdi_o !== 4'h0) begin
            n_fail++; $display("FAIL arm cur=%0d busy=%b done=%b sdi=%h exp=1 1 0 0", cur_src_o, busy_o, done_o, pulp_spi_sdi_o); end
        step();
        n_tests++; if (cur_src_o !== 2'd1 || busy_o !== 1'b0 || done_o !== 1'b1 || pulp_spi_sdi_o !== 4'hC) begin
            n_fail++; $display("FAIL switch_done cur=%0d busy=%b done=%b sdi=%h exp=1 0 1 c", cur_src_o, busy_o, done_o, pulp_spi_sdi_o); end
        csn[1] = 4'hD; #1;
        n_tests++; if (pulp_spi_csn_o !== 4'hD) begin n_fail++; $display("FAIL pass_src1 csn=%h exp=d", pulp_spi_csn_o); end
        step();
        n_tests++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL done_pulse_len got=%b exp=0", done_o); end
    endtask

    task automatic test_timeout();
        csn[1] = 4'h0; csn[0] = 4'hF; pulp_spi_sdo_i = 4'hA;
        request(2'd0);
        repeat (49) step();
        n_tests++; if (busy_o !== 1'b1 || pulp_spi_sdi_o !== 4'hC || err_abort_o !== 1'b0) begin
            n_fail++; $display("FAIL tmo_pre busy=%b sdi=%h abort=%b exp=1 c 0", busy_o, pulp_spi_sdi_o, err_abort_o); end
        step();
        n_tests++; if (pulp_spi_sdi_o !== 4'h0 || pulp_spi_csn_o !== 4'hF || err_abort_o !== 1'b1 || src_miso_o !== '0) begin
            n_fail++; $display("FAIL tmo_blank sdi=%h csn=%h abort=%b miso=%h exp=0 f 1 0", pulp_spi_sdi_o, pulp_spi_csn_o, err_abort_o, src_miso_o); end
        repeat (8) step();
        n_tests++; if (cur_src_o !== 2'd0 || busy_o !== 1'b1) begin n_fail++; $display("FAIL tmo_arm cur=%0d busy=%b exp=0 1", cur_src_o, busy_o); end
        step();
        n_tests++; if (busy_o !== 1'b0 || done_o !== 1'b1 || err_abort_o !== 1'b1) begin
            n_fail++; $display("FAIL tmo_done busy=%b done=%b abort=%b exp=0 1 1", busy_o, done_o, err_abort_o); end
        csn[1] = 4'hF; pulp_spi_sdo_i = 4'h0;
    endtask

    task automatic test_bad_src();
        request(2'd3);
        n_tests++; if (err_bad_src_o !== 1'b1 || done_o !== 1'b0 || cur_src_o !== 2'd0 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL bad_src err=%b done=%b cur=%0d busy=%b exp=1 0 0 0", err_bad_src_o, done_o, cur_src_o, busy_o); end
        err_clr_i = 1'b1;
        request(2'd3);
        n_tests++; if (err_bad_src_o !== 1'b1 || err_abort_o !== 1'b0) begin
            n_fail++; $display("FAIL clr_set_wins bad=%b abort=%b exp=1 0", err_bad_src_o, err_abort_o); end
        step();
        n_tests++; if (err_bad_src_o !== 1'b0) begin n_fail++; $display("FAIL err_clr bad=%b exp=0", err_bad_src_o); end
        err_clr_i = 1'b0;
    endtask

    task automatic test_same_src();
        request(2'd0);
        n_tests++; if (done_o !== 1'b1 || busy_o !== 1'b0 || cur_src_o !== 2'd0) begin
            n_fail++; $display("FAIL same_src done=%b busy=%b cur=%0d exp=1 0 0", done_o, busy_o, cur_src_o); end
        step();
        n_tests++; if (done_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL same_src_after done=%b busy=%b exp=0 0", done_o, busy_o); end
    endtask

    task automatic test_quad();
        pulp_spi_mode_i = 2'b01; pulp_spi_sdo_i = 4'hA; #1;
        n_tests++; if (src_miso_o !== 12'h00A || src_mode_o !== 6'b000001) begin
            n_fail++; $display("FAIL quad_tx miso=%h mode=%b exp=00a 000001", src_miso_o, src_mode_o); end
        pulp_spi_mode_i = 2'b10; pulp_spi_sdo_i = 4'h5; #1;
        n_tests++; if (src_miso_o !== 12'h005 || src_mode_o !== 6'b000010) begin
            n_fail++; $display("FAIL quad_rx miso=%h mode=%b exp=005 000010", src_miso_o, src_mode_o); end
        pulp_spi_mode_i = 2'b00; pulp_spi_sdo_i = 4'h0;
    endtask

    task automatic test_reset_midswitch();
        int cyc;
        csn[0] = 4'h7; mosi[0] = 4'h3;
        request(2'd2);
        n_tests++; if (pulp_spi_sdi_o !== 4'h3 || busy_o !== 1'b1) begin
            n_fail++; $display("FAIL mid_drain sdi=%h busy=%b exp=3 1", pulp_spi_sdi_o, busy_o); end
        rst = 1'b1; #1;
        n_tests++; if (pulp_spi_sdi_o !== 4'h0 || pulp_spi_csn_o !== 4'hF || busy_o !== 1'b1 || sel_ready_o !== 1'b0 || cur_src_o !== 2'd0) begin
            n_fail++; $display("FAIL async_rst sdi=%h csn=%h busy=%b ready=%b cur=%0d exp=0 f 1 0 0",
                               pulp_spi_sdi_o, pulp_spi_csn_o, busy_o, sel_ready_o, cur_src_o); end
        step(); rst = 1'b0;
        repeat (6) step();
        n_tests++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL arm_midframe busy=%b exp=1", busy_o); end
        csn[0] = 4'hF;
        cyc = 0;
        while (busy_o === 1'b1 && cyc < 10) begin step(); cyc++; end
        n_tests++; if (busy_o !== 1'b0 || done_o !== 1'b0 || cyc != 3) begin
            n_fail++; $display("FAIL rearm busy=%b done=%b cyc=%0d exp=0 0 3", busy_o, done_o, cyc); end
    endtask

    initial begin
        test_reset();
        test_drain_switch();
        test_timeout();
        test_bad_src();
        test_same_src();
        test_quad();
        test_reset_midswitch();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
